instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle control unit that fetches 16-bit instructions from program memory and drives the register file and ALU.
- It is the initiator side of the register-file read/write interface and of the ALU op interface.
- It sits between the ROM (combinational read on an 8-bit address) and the datapath (register file plus registered 8-bit ALU with zero flag).
- Sequences FETCH/DECODE/EXEC/WB and handles jump, branch-on-zero and halt.

Parameters:
- PC_WIDTH, 8, program counter and ROM address width.
- RESET_PC, 0, PC value loaded on reset and on start.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; begins execution from RESET_PC when in IDLE or HALT.
- instruction  in  16  ROM data for address pc, valid in the same cycle.
- zero_flag  in  1  ALU zero flag, registered in the ALU.
- pc  out  PC_WIDTH  ROM address.
- sel_a  out  4  register-file read select A.
- sel_b  out  4  register-file read select B.
- sel_write  out  4  register-file write select.
- write_en  out  1  register-file write strobe, one cycle.
- alu_op  out  3  ALU operation code.
- imm_sel  out  1  1 = datapath feeds imm to ALU srcB instead of register B.
- imm  out  8  immediate field.
- busy  out  1  high in any state other than IDLE or HALT.
- halted  out  1  high in HALT.

Behaviour:
Reset and clocking:
- reset is asynchronous, active-low; clock is clock.
- While reset is low: state=IDLE, pc=RESET_PC, ir=0, and all outputs are 0.
- Reset asserted mid-instruction aborts it; no write_en pulse may escape.

Instruction format (ir):
- ir[15]=0 is an ALU op: op=ir[14:12], dst=ir[11:8], srcA=ir[7:4], srcB=ir[3:0].
- ir[15]=1 is a control op, selected by ir[14:12]:
  - 000 LDI: dst=ir[11:8], imm=ir[7:0]; issued as ALU op 111 with imm_sel=1.
  - 001 JMP: target=ir[7:0].
  - 010 BZ: branch to ir[7:0] if zero_flag=1.
  - 011 HALT.
  - 100..111 NOP.

FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: when start=1, set pc=RESET_PC and go to FETCH.
- FETCH: pc is driven; ir<=instruction at the edge; go to DECODE.
- DECODE, depending on the instruction:
  - ALU/LDI: drive sel_a, sel_b, alu_op, imm_sel, imm; go to EXEC.
  - JMP: pc<=target; go to FETCH.
  - BZ taken: pc<=target. BZ not taken: pc<=pc+1. Either way go to FETCH.
  - NOP: pc<=pc+1; go to FETCH.
  - HALT: go to HALT; pc unchanged.
- EXEC: hold DECODE outputs; the ALU captures its result at the closing edge; go to WB.
- WB: hold sel_a/sel_b/alu_op; sel_write=dst, write_en=1 for exactly this cycle; pc<=pc+1; go to FETCH.
- HALT: halted=1; outputs other than pc are 0. start=1 sets pc=RESET_PC and goes to FETCH.

Cycle counts and outputs outside active states:
- ALU/LDI instruction: 4 cycles. JMP/BZ/NOP: 2 cycles.
- sel_*, alu_op, imm_sel, imm are 0 in IDLE, FETCH and HALT.
- write_en is 1 only in WB.

Boundary conditions:
- pc increments modulo 2^PC_WIDTH (255 -> 0). JMP to the current pc is legal and loops.
- BZ samples zero_flag in DECODE. The value reflects the most recent ALU op; the ALU sets the flag only for add/sub.
- dst equal to srcA or srcB is legal. Reads complete in EXEC, before the WB write.
- start held high while busy is ignored.

Decomposition:
- Package instr_seq_pkg holds:
  - State encodings (3-bit localparams).
  - Control subopcodes: SUB_LDI=3'b000, SUB_JMP=3'b001, SUB_BZ=3'b010, SUB_HALT=3'b011.
  - ALU op constant ALU_PASSB=3'b111.
  - Field bit positions.
- One natural combinational sub-module, instr_field_decode:
  - Input: ir.
  - Outputs: is_alu, is_ldi, is_jmp, is_bz, is_halt, op, dst, src_a, src_b, imm.
- The FSM, pc and ir registers stay in instr_sequencer.

Test Plan:
- Reset and idle: reset low during an ALU op's WB cycle -> write_en=0 immediately, pc=0, state IDLE, busy=0.
- ALU op: ROM[0]=16'h2312 (add r3=r1+r2) -> after start, DECODE drives sel_a=1, sel_b=2, alu_op=010; WB drives sel_write=3, write_en=1 for one cycle; pc=1 after 4 cycles.
- LDI: ROM[0]=16'h8545 -> alu_op=111, imm_sel=1, imm=8'h45; WB sel_write=5; pc=1.
- JMP then wrap: ROM[0]=16'h90FF, ROM[255]=NOP -> pc=255 after 2 cycles, then pc=0 after 2 more.
- BZ both ways:
  - zero_flag=1 with ROM[0]=16'hA010 -> pc=16.
  - zero_flag=0 -> pc=1.
- HALT and restart: ROM[2]=16'hB000 -> halted=1 and pc holds 2; start=1 -> pc=0, busy=1 next cycle.

Source files
------------

// File: rtl/instr_seq_pkg.sv
// instr_seq_pkg: shared state encodings, control subopcodes and instruction field positions.
package instr_seq_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;
  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_EXEC   = ST_EXEC,
    S_WB     = ST_WB,
    S_HALT   = ST_HALT
  } state_e;
  localparam logic [2:0] SUB_LDI   = 3'b000;
  localparam logic [2:0] SUB_JMP   = 3'b001;
  localparam logic [2:0] SUB_BZ    = 3'b010;
  localparam logic [2:0] SUB_HALT  = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b111;
  localparam int CTRL_BIT = 15;
  localparam int OP_MSB   = 14;
  localparam int DST_MSB  = 11;
  localparam int SRCA_MSB = 7;
  localparam int SRCB_MSB = 3;
  localparam int IMM_MSB  = 7;
endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: splits a 16-bit instruction into its class flags and operand fields.
module instr_field_decode
  import instr_seq_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic        is_alu_o,
  output logic        is_ldi_o,
  output logic        is_jmp_o,
  output logic        is_bz_o,
  output logic        is_halt_o,
  output logic [2:0]  op_o,
  output logic [3:0]  dst_o,
  output logic [3:0]  src_a_o,
  output logic [3:0]  src_b_o,
  output logic [7:0]  imm_o
);
  always_comb begin
    op_o      = ir_i[OP_MSB -: 3];
    dst_o     = ir_i[DST_MSB -: 4];
    src_a_o   = ir_i[SRCA_MSB -: 4];
    src_b_o   = ir_i[SRCB_MSB -: 4];
    imm_o     = ir_i[IMM_MSB -: 8];
    is_alu_o  = !ir_i[CTRL_BIT];
    is_ldi_o  = ir_i[CTRL_BIT] && (op_o == SUB_LDI);
    is_jmp_o  = ir_i[CTRL_BIT] && (op_o == SUB_JMP);
    is_bz_o   = ir_i[CTRL_BIT] && (op_o == SUB_BZ);
    is_halt_o = ir_i[CTRL_BIT] && (op_o == SUB_HALT);
  end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: FETCH/DECODE/EXEC/WB control unit driving register file and ALU from a ROM.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int                   PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [15:0]         instruction,
  input  logic                zero_flag,
  output logic [PC_WIDTH-1:0] pc,
  output logic [3:0]          sel_a,
  output logic [3:0]          sel_b,
  output logic [3:0]          sel_write,
  output logic                write_en,
  output logic [2:0]          alu_op,
  output logic                imm_sel,
  output logic [7:0]          imm,
  output logic                busy,
  output logic                halted
);
  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic                is_alu, is_ldi, is_jmp, is_bz, is_halt, issue;
  logic [2:0]          op;
  logic [3:0]          dst, src_a, src_b;
  logic [7:0]          imm_f;
  logic [PC_WIDTH-1:0] pc_inc, target;
  instr_field_decode u_dec (
    .ir_i      (ir_q),
    .is_alu_o  (is_alu),
    .is_ldi_o  (is_ldi),
    .is_jmp_o  (is_jmp),
    .is_bz_o   (is_bz),
    .is_halt_o (is_halt),
    .op_o      (op),
    .dst_o     (dst),
    .src_a_o   (src_a),
    .src_b_o   (src_b),
    .imm_o     (imm_f)
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end
  assign pc_inc = pc_q + PC_WIDTH'(1);
  assign target = PC_WIDTH'(imm_f);
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        state_d = start ? S_FETCH : state_q;
        pc_d    = start ? RESET_PC : pc_q;
      end
      S_FETCH: begin
        ir_d    = instruction;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (is_alu || is_ldi) ? S_EXEC : is_halt ? S_HALT : S_FETCH;
        pc_d    = (is_alu || is_ldi || is_halt) ? pc_q
                : (is_jmp || (is_bz && zero_flag)) ? target : pc_inc;
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // ALU/LDI operands stay on the bus from DECODE through WB so reads settle before the write.
  assign issue     = (state_q == S_DECODE || state_q == S_EXEC || state_q == S_WB) && (is_alu || is_ldi);
  assign pc        = pc_q;
  assign sel_a     = (issue && is_alu) ? src_a : 4'd0;
  assign sel_b     = (issue && is_alu) ? src_b : 4'd0;
  assign alu_op    = issue ? (is_ldi ? ALU_PASSB : op) : 3'd0;
  assign imm_sel   = issue && is_ldi;
  assign imm       = (issue && is_ldi) ? imm_f : 8'd0;
  assign write_en  = (state_q == S_WB);
  assign sel_write = write_en ? dst : 4'd0;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted    = (state_q == S_HALT);
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: table-driven scoreboard bench for instr_sequencer with a ROM model.
module tb_instr_sequencer;
  typedef struct packed {
    logic [7:0] pc;
    logic [3:0] sa, sb, sw;
    logic       we;
    logic [2:0] op;
    logic       isel;
    logic [7:0] imm;
    logic       busy, halted;
  } obs_t;
  typedef struct {
    string       name;
    logic [15:0] instr;
    logic        zf, hold;
    int          kind;
    logic [3:0]  sa, sb, sw;
    logic [2:0]  op;
    logic        isel;
    logic [7:0]  imm, npc;
  } vec_t;
  localparam logic [15:0] NOP = 16'hC000;
  logic        clock, reset, start, zero_flag, write_en, imm_sel, busy, halted;
  logic [15:0] instruction;
  logic [7:0]  pc, imm;
  logic [3:0]  sel_a, sel_b, sel_write;
  logic [2:0]  alu_op;
  logic [15:0] rom [256];
  obs_t        sb_q [$];
  vec_t        vt [10];
  int          checks = 0, failures = 0;
  instr_sequencer #(.PC_WIDTH(8), .RESET_PC(8'd0)) dut (
    .clock(clock), .reset(reset), .start(start), .instruction(instruction),
    .zero_flag(zero_flag), .pc(pc), .sel_a(sel_a), .sel_b(sel_b),
    .sel_write(sel_write), .write_en(write_en), .alu_op(alu_op),
    .imm_sel(imm_sel), .imm(imm), .busy(busy), .halted(halted)
  );
  assign instruction = rom[pc];
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic obs_t obs(input logic [7:0] p, input logic b, input logic h);
    obs_t o = '0;
    o.pc = p; o.busy = b; o.halted = h;
    return o;
  endfunction
  function automatic obs_t iss(input logic [7:0] p, input vec_t v, input logic we);
    obs_t o = obs(p, 1'b1, 1'b0);
    o.sa = v.sa; o.sb = v.sb; o.op = v.op; o.isel = v.isel; o.imm = v.imm;
    o.we = we; o.sw = we ? v.sw : 4'd0;
    return o;
  endfunction
  function automatic vec_t mkv(input string n, input logic [15:0] ins, input logic zf, input logic hold,
                               input int kind, input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] sw,
                               input logic [2:0] op, input logic isel, input logic [7:0] im, input logic [7:0] npc);
    vec_t v;
    v.name = n; v.instr = ins; v.zf = zf; v.hold = hold; v.kind = kind;
    v.sa = sa; v.sb = sb; v.sw = sw; v.op = op; v.isel = isel; v.imm = im; v.npc = npc;
    return v;
  endfunction
  task automatic check(input string name);
    obs_t a, e;
    a = '{pc, sel_a, sel_b, sel_write, write_en, alu_op, imm_sel, imm, busy, halted};
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got pc=%h sa=%h sb=%h sw=%h we=%b op=%b isel=%b imm=%h busy=%b halted=%b, want pc=%h sa=%h sb=%h sw=%h we=%b op=%b isel=%b imm=%h busy=%b halted=%b",
                 name, a.pc, a.sa, a.sb, a.sw, a.we, a.op, a.isel, a.imm, a.busy, a.halted,
                 e.pc, e.sa, e.sb, e.sw, e.we, e.op, e.isel, e.imm, e.busy, e.halted);
      end
    end
  endtask
  task automatic drain(input string name);
    while (sb_q.size() > 0) begin
      check(name);
      @(negedge clock);
    end
  endtask
  task automatic reset_and_start(input string name, input logic hold);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    sb_q.push_back(obs(8'd0, 1'b0, 1'b0));
    check({name, "/reset"});
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = hold;
  endtask
  task automatic run_vec(input vec_t v);
    for (int i = 0; i < 256; i++) rom[i] = NOP;
    rom[0] = v.instr;
    zero_flag = v.zf;
    reset_and_start(v.name, v.hold);
    sb_q.push_back(obs(8'd0, 1'b1, 1'b0));
    if (v.kind == 1) begin
      sb_q.push_back(iss(8'd0, v, 1'b0));
      sb_q.push_back(iss(8'd0, v, 1'b0));
      sb_q.push_back(iss(8'd0, v, 1'b1));
      sb_q.push_back(obs(v.npc, 1'b1, 1'b0));
    end else if (v.kind == 2) begin
      sb_q.push_back(obs(8'd0, 1'b1, 1'b0));
      sb_q.push_back(obs(8'd0, 1'b0, 1'b1));
      sb_q.push_back(obs(8'd0, 1'b0, 1'b1));
    end else begin
      sb_q.push_back(obs(8'd0, 1'b1, 1'b0));
      sb_q.push_back(obs(v.npc, 1'b1, 1'b0));
    end
    drain(v.name);
    start = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b0; start = 1'b0; zero_flag = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = NOP;
    vt[0] = mkv("add",      16'h2312, 0, 0, 1, 4'h1, 4'h2, 4'h3, 3'b010, 0, 8'h00, 8'h01);
    vt[1] = mkv("ldi",      16'h8545, 0, 0, 1, 4'h0, 4'h0, 4'h5, 3'b111, 1, 8'h45, 8'h01);
    vt[2] = mkv("jmp",      16'h90FF, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0, 8'h00, 8'hFF);
    vt[3] = mkv("bz_taken", 16'hA010, 1, 0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0, 8'h00, 8'h10);
    vt[4] = mkv("bz_not",   16'hA010, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0, 8'h00, 8'h01);
    vt[5] = mkv("nop",      NOP,      1, 0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0, 8'h00, 8'h01);
    vt[6] = mkv("dst_eq_b", 16'h3A4A, 1, 0, 1, 4'h4, 4'hA, 4'hA, 3'b011, 0, 8'h00, 8'h01);
    vt[7] = mkv("halt",     16'hB000, 0, 0, 2, 4'h0, 4'h0, 4'h0, 3'b000, 0, 8'h00, 8'h00);
    vt[8] = mkv("all_ones", 16'h7FFF, 0, 0, 1, 4'hF, 4'hF, 4'hF, 3'b111, 0, 8'h00, 8'h01);
    vt[9] = mkv("start_held", 16'h2312, 0, 1, 1, 4'h1, 4'h2, 4'h3, 3'b010, 0, 8'h00, 8'h01);
    for (int i = 0; i < 10; i++) run_vec(vt[i]);
    // JMP to 255, NOP there, pc wraps to 0
    for (int i = 0; i < 256; i++) rom[i] = NOP;
    rom[0] = 16'h90FF;
    reset_and_start("wrap", 1'b0);
    sb_q.push_back(obs(8'd0, 1'b1, 1'b0));
    sb_q.push_back(obs(8'd0, 1'b1, 1'b0));
    sb_q.push_back(obs(8'hFF, 1'b1, 1'b0));
    sb_q.push_back(obs(8'hFF, 1'b1, 1'b0));
    sb_q.push_back(obs(8'h00, 1'b1, 1'b0));
    drain("wrap");
    // HALT at pc 2, then restart
    for (int i = 0; i < 256; i++) rom[i] = NOP;
    rom[2] = 16'hB000;
    reset_and_start("halt_restart", 1'b0);
    for (int p = 0; p < 3; p++) begin
      sb_q.push_back(obs(8'(p), 1'b1, 1'b0));
      sb_q.push_back(obs(8'(p), 1'b1, 1'b0));
    end
    sb_q.push_back(obs(8'd2, 1'b0, 1'b1));
    sb_q.push_back(obs(8'd2, 1'b0, 1'b1));
    drain("halt_hold");
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    sb_q.push_back(obs(8'd0, 1'b1, 1'b0));
    sb_q.push_back(obs(8'd0, 1'b1, 1'b0));
    sb_q.push_back(obs(8'd1, 1'b1, 1'b0));
    drain("restart");
    // Reset asserted during WB must kill write_en at once
    for (int i = 0; i < 256; i++) rom[i] = NOP;
    rom[0] = 16'h2312;
    reset_and_start("abort", 1'b0);
    sb_q.push_back(obs(8'd0, 1'b1, 1'b0));
    sb_q.push_back(iss(8'd0, vt[0], 1'b0));
    sb_q.push_back(iss(8'd0, vt[0], 1'b0));
    sb_q.push_back(iss(8'd0, vt[0], 1'b1));
    for (int i = 0; i < 4; i++) begin
      check("abort_pre");
      if (i < 3) @(negedge clock);
    end
    #2 reset = 1'b0;
    #1 sb_q.push_back(obs(8'd0, 1'b0, 1'b0));
    check("abort_now");
    @(negedge clock);
    sb_q.push_back(obs(8'd0, 1'b0, 1'b0));
    check("abort_idle");
    reset = 1'b1;
    @(negedge clock);
    sb_q.push_back(obs(8'd0, 1'b0, 1'b0));
    check("idle_no_start");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
